// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   FRAME_W      : bits per serial frame (start + 7 data + 2 config + stop)
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of stop bits and the idle line
//   LAST_BIT     : index of the final bit period in a frame
//   tx_state_e   : transmit engine state encoding
//   calc_parity  : parity over 7 or 8 data bits, even or odd sense
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_W   = 11;
  localparam int BIT_CNT_W = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = 4'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  // Parity over D[7:0] (eight=1) or D[6:0] (eight=0).
  // odd=0 gives even parity (plain XOR), odd=1 inverts it.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       eight,
                                       input logic       odd);
    logic [7:0] bits;
    bits = eight ? data : {1'b0, data[6:0]};
    return (^bits) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_engine_frame_builder.sv
// ---------------------------------------------------------------------------
// tx_frame_builder
// Combinational construction of the 11-bit transmit frame, bit 0 sent first.
// Mirror image of the receive-side right-justification: data always starts
// at bit 1, and positions not used by the configured format become extra
// stop bits so every frame lasts 11 bit times.
// Ports:
//   data   in  8        byte to send
//   eight  in  1        1 = 8 data bits, 0 = 7 data bits
//   pen    in  1        parity enable
//   ohel   in  1        parity sense, 1 = odd, 0 = even
//   frame  out FRAME_W  frame image, frame[0] = start bit
// ---------------------------------------------------------------------------
module tx_frame_builder
  import uart_pkg::*;
(
  input  logic [7:0]         data,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  output logic [FRAME_W-1:0] frame
);

  logic par;

  assign par = calc_parity(data, eight, ohel);

  assign frame[0] = START_BIT;

  // D[6:0] always lands in bits 7:1.
  genvar gi;
  generate
    for (gi = 1; gi <= 7; gi++) begin : g_data
      assign frame[gi] = data[gi-1];
    end
  endgenerate

  // Bit 8 carries D[7] in 8-bit mode, otherwise parity (if enabled) or stop.
  assign frame[8]  = eight ? data[7] : (pen ? par : STOP_BIT);
  // Bit 9 carries parity only when both the 8th data bit and parity are used.
  assign frame[9]  = (eight && pen) ? par : STOP_BIT;
  assign frame[10] = STOP_BIT;

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Transmit half of the UART. Accepts a byte on a one-cycle LOAD strobe while
// TXRDY=1, latches the frame, configuration and bit time, then shifts the
// 11-bit frame out LSB-first, each bit held max(BAUD_K,1) clocks.
// Optional feature (macro UART_TX_BREAK_EN): adds the BREAK input. BREAK=1
// while idle drives the line low and holds TXRDY low; BREAK raised during a
// frame takes effect once the frame has completed.
// Ports:
//   CLK       in  1      system clock, rising edge
//   RESET_N   in  1      asynchronous active-low reset
//   LOAD      in  1      write strobe, accepted only while TXRDY=1
//   OUT_PORT  in  8      byte to transmit
//   EIGHT     in  1      1 = 8 data bits, 0 = 7 data bits
//   PEN       in  1      parity enable
//   OHEL      in  1      parity sense, 1 = odd, 0 = even
//   BAUD_K    in  CNT_W  clocks per bit, 0 treated as 1
//   BREAK     in  1      line break request (UART_TX_BREAK_EN only)
//   TX        out 1      serial line, idles high
//   TXRDY     out 1      idle and able to accept LOAD
// ---------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOAD,
  input  logic [7:0]       OUT_PORT,
  input  logic             EIGHT,
  input  logic             PEN,
  input  logic             OHEL,
  input  logic [CNT_W-1:0] BAUD_K,
`ifdef UART_TX_BREAK_EN
  input  logic             BREAK,
`endif
  output logic             TX,
  output logic             TXRDY
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  tx_state_e              state_reg, state_next;
  logic [FRAME_W-1:0]     sr_reg, sr_next;
  logic [CNT_W-1:0]       baud_reg, baud_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic                   brk_reg, brk_next;
  logic                   tx_reg, tx_next;
  logic                   txrdy_reg, txrdy_next;

  logic [FRAME_W-1:0]     frame;
  logic [CNT_W-1:0]       baud_eff;
  logic                   break_req;
  logic                   load_accept;
  logic                   bit_end;

`ifdef UART_TX_BREAK_EN
  assign break_req = BREAK;
`else
  assign break_req = 1'b0;
`endif

  tx_frame_builder u_frame_builder (
    .data  (OUT_PORT),
    .eight (EIGHT),
    .pen   (PEN),
    .ohel  (OHEL),
    .frame (frame)
  );

  assign baud_eff = (BAUD_K == '0) ? CNT_ONE : BAUD_K;

  // A break request seen in the same cycle as LOAD wins; the byte is dropped.
  assign load_accept = LOAD && (state_reg == IDLE) && !brk_reg && !break_req;

  // baud_reg is never zero while shifting, so the subtraction cannot wrap.
  assign bit_end = (cnt_reg == (baud_reg - CNT_ONE));

  always_comb begin
    state_next   = state_reg;
    sr_next      = sr_reg;
    baud_next    = baud_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    brk_next     = brk_reg;

    case (state_reg)
      IDLE: begin
        // Break is only ever entered from idle, so a request raised during
        // a frame naturally waits here until the frame has gone out.
        brk_next = break_req;
        if (load_accept) begin
          state_next   = SHIFT;
          sr_next      = frame;
          baud_next    = baud_eff;
          cnt_next     = '0;
          bit_cnt_next = '0;
        end
      end

      SHIFT: begin
        brk_next = 1'b0;
        if (bit_end) begin
          cnt_next = '0;
          sr_next  = {STOP_BIT, sr_reg[FRAME_W-1:1]};
          if (bit_cnt_reg == LAST_BIT) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next-state values so TX and TXRDY
    // come straight off flops and cannot glitch.
    if (brk_next) begin
      tx_next = 1'b0;
    end else if (state_next == SHIFT) begin
      tx_next = sr_next[0];
    end else begin
      tx_next = STOP_BIT;
    end
    txrdy_next = (state_next == IDLE) && !brk_next;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      sr_reg      <= '0;
      baud_reg    <= '0;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      brk_reg     <= 1'b0;
      tx_reg      <= STOP_BIT;
      txrdy_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      baud_reg    <= baud_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      brk_reg     <= brk_next;
      tx_reg      <= tx_next;
      txrdy_reg   <= txrdy_next;
    end
  end

  assign TX    = tx_reg;
  assign TXRDY = txrdy_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed testbench for uart_tx_engine. Each frame is compared bit by bit
// against a hand-computed 11-bit image (index i = i-th bit on the line).
// Break checks are included when UART_TX_BREAK_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int CNT_W = 20;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             LOAD;
  logic [7:0]       OUT_PORT;
  logic             EIGHT;
  logic             PEN;
  logic             OHEL;
  logic [CNT_W-1:0] BAUD_K;
`ifdef UART_TX_BREAK_EN
  logic             BREAK;
`endif
  logic             TX;
  logic             TXRDY;

  int err_cnt = 0;
  int chk_cnt = 0;

  uart_tx_engine #(.CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .LOAD     (LOAD),
    .OUT_PORT (OUT_PORT),
    .EIGHT    (EIGHT),
    .PEN      (PEN),
    .OHEL     (OHEL),
    .BAUD_K   (BAUD_K),
`ifdef UART_TX_BREAK_EN
    .BREAK    (BREAK),
`endif
    .TX       (TX),
    .TXRDY    (TXRDY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame starting from a point #1 after a clock edge and returns
  // #1 after the edge on which TXRDY should have risen again.
  //   inj_at   : cycle index at which a spurious LOAD of 8'hFF with flipped
  //              config and BAUD_K is presented (-1 = none)
  //   abort_at : cycle index at which RESET_N is pulsed low (-1 = none)
  task automatic run_frame(input string name, input logic [7:0] d,
                           input logic e, input logic p, input logic o,
                           input logic [CNT_W-1:0] k, input logic [10:0] expv,
                           input int inj_at, input int abort_at);
    int hold;
    int cyc;
    int errs_before;
    hold        = (k == 0) ? 1 : int'(k);
    errs_before = err_cnt;
    OUT_PORT = d;
    EIGHT    = e;
    PEN      = p;
    OHEL     = o;
    BAUD_K   = k;
    LOAD     = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b0;
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < hold; c++) begin
        cyc = i * hold + c;
        if (cyc == abort_at) begin
          #2 RESET_N = 1'b0;
          #1;
          check($sformatf("%s rst_tx", name), TX, 1);
          check($sformatf("%s rst_txrdy", name), TXRDY, 1);
          @(negedge CLK);
          RESET_N = 1'b1;
          @(posedge CLK); #1;
          check($sformatf("%s post_rst_txrdy", name), TXRDY, 1);
          $display("frame %s data=%02h aborted at bit %0d", name, d, i);
          return;
        end
        check($sformatf("%s bit%0d c%0d", name, i, c), TX, expv[i]);
        check($sformatf("%s busy c%0d", name, cyc), TXRDY, 0);
        if (cyc == inj_at) begin
          LOAD     = 1'b1;
          OUT_PORT = 8'hFF;
          EIGHT    = ~e;
          PEN      = ~p;
          OHEL     = ~o;
          BAUD_K   = k + 3;
        end else begin
          LOAD = 1'b0;
        end
        @(posedge CLK); #1;
      end
    end
    LOAD = 1'b0;
    check($sformatf("%s done_txrdy", name), TXRDY, 1);
    check($sformatf("%s done_tx", name), TX, 1);
    $display("frame %s data=%02h k=%0d errors=%0d", name, d, k, err_cnt - errs_before);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N  = 1'b0;
    LOAD     = 1'b0;
    OUT_PORT = 8'h00;
    EIGHT    = 1'b1;
    PEN      = 1'b0;
    OHEL     = 1'b0;
    BAUD_K   = 20'd4;
`ifdef UART_TX_BREAK_EN
    BREAK    = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check("reset tx", TX, 1);
    check("reset txrdy", TXRDY, 1);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("idle tx", TX, 1);
    check("idle txrdy", TXRDY, 1);
    $display("reset released, line idle");

    // 8 data bits, even parity: 0,1,0,1,0,0,1,0,1,0,1
    run_frame("a5_8e", 8'hA5, 1'b1, 1'b1, 1'b0, 20'd4, 11'b10101001010, -1, -1);
    // 7 data bits, no parity: 0,1,0,0,0,0,0,1,1,1,1
    run_frame("41_7n", 8'h41, 1'b0, 1'b0, 1'b0, 20'd4, 11'b11110000010, -1, -1);
    // 7 data bits, odd parity over 0000011 -> parity 1
    run_frame("03_7o", 8'h03, 1'b0, 1'b1, 1'b1, 20'd4, 11'b11100000110, -1, -1);
    // 8 data bits, odd parity over 10000000 -> parity 0
    run_frame("80_8o", 8'h80, 1'b1, 1'b1, 1'b1, 20'd1, 11'b10100000000, -1, -1);
    // Spurious LOAD of FF with flipped config mid-frame must be ignored
    run_frame("00_8e_inj", 8'h00, 1'b1, 1'b1, 1'b0, 20'd2, 11'b10000000000, 5, -1);
    // LOAD in the first TXRDY=1 cycle: start bit follows on the next edge
    run_frame("5a_8n_b2b", 8'h5A, 1'b1, 1'b0, 1'b0, 20'd2, 11'b11010110100, -1, -1);
    // Reset pulsed during bit 5, then a fresh complete frame
    run_frame("a5_rst", 8'hA5, 1'b1, 1'b1, 1'b0, 20'd4, 11'b10101001010, -1, 20);
    run_frame("a5_after", 8'hA5, 1'b1, 1'b1, 1'b0, 20'd4, 11'b10101001010, -1, -1);
    // BAUD_K=0 behaves as 1: 11-clock frame
    run_frame("41_k0", 8'h41, 1'b0, 1'b0, 1'b0, 20'd0, 11'b11110000010, -1, -1);

`ifdef UART_TX_BREAK_EN
    BREAK    = 1'b1;
    LOAD     = 1'b1;
    OUT_PORT = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      check($sformatf("break tx c%0d", i), TX, 0);
      check($sformatf("break txrdy c%0d", i), TXRDY, 0);
    end
    BREAK = 1'b0;
    LOAD  = 1'b0;
    @(posedge CLK); #1;
    check("break release tx", TX, 1);
    check("break release txrdy", TXRDY, 1);
    $display("break held 20 clocks, LOAD ignored");
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
